// File: rtl/act_pkg.sv
// Shared types and encodings for the activation-port scheduler.
package act_pkg;

  localparam int LenWidthDef = 8;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_FILL,
    ST_FLOW,
    ST_DRAIN,
    ST_LOAD,
    ST_DRIVE,
    ST_TURN
  } act_state_e;

  localparam logic [1:0] SEL_NONE = 2'b00;
  localparam logic [1:0] SEL_ACT1 = 2'b10;
  localparam logic [1:0] SEL_ACT2 = 2'b11;

  // Port index (0 = act1, 1 = act2) to unit input select.
  function automatic logic [1:0] sel_of(input logic port);
    return port ? SEL_ACT2 : SEL_ACT1;
  endfunction

endpackage

// File: rtl/act_port_sched_if.sv
// Request/grant and unit-select bundle between the two ports and the scheduler.
interface act_port_sched_if
  import act_pkg::*;
#(
  parameter int LenWidth = LenWidthDef
);
  logic                req1, req2;
  logic                dst1, dst2;
  logic [LenWidth-1:0] len1, len2;
  logic                gnt1, gnt2;
  logic [1:0]          sel_i;
  logic                sel_o1, sel_o2;
  logic                busy, done;

  modport slave (
    input  req1, req2, dst1, dst2, len1, len2,
    output gnt1, gnt2, sel_i, sel_o1, sel_o2, busy, done
  );

  modport master (
    output req1, req2, dst1, dst2, len1, len2,
    input  gnt1, gnt2, sel_i, sel_o1, sel_o2, busy, done
  );
endinterface

// File: rtl/act_rr_arb.sv
// Two-requester round-robin arbiter; grants only while enabled.
module act_rr_arb (
  input  logic       clk,
  input  logic       rst,
  input  logic [1:0] req,
  input  logic       en,
  output logic [1:0] gnt,
  output logic       ptr
);

  // One-hot pick: a lone requester always wins, a tie goes to the pointer.
  always_comb begin
    gnt = 2'b00;
    if (en) begin
      if (req == 2'b11) gnt = ptr ? 2'b10 : 2'b01;
      else              gnt = req;
    end
  end

  // Pointer favours the port that was not just granted (0 = req1).
  always_ff @(posedge clk or negedge rst) begin
    if (!rst)        ptr <= 1'b0;
    else if (gnt[0]) ptr <= 1'b1;
    else if (gnt[1]) ptr <= 1'b0;
  end

endmodule

// File: rtl/act_port_sched.sv
// Burst sequencer for the shared activation unit: arbitrates act1/act2,
// steers the unit's input select and output enables, and inserts a
// turnaround cycle after every burst. All outputs are registered, so they
// trail the state register by one cycle.
module act_port_sched
  import act_pkg::*;
#(
  parameter int LenWidth = LenWidthDef
) (
  input logic             clk,
  input logic             rst,
  act_port_sched_if.slave bus
);

  act_state_e          state, state_nx;
  logic                dst, dst_nx, src;
  logic [LenWidth-1:0] cnt, cnt_nx;
  logic                cnt_z;
  logic [1:0]          arb_gnt;
  logic                arb_ptr;
  logic [1:0]          sel_i_nx, sel_o_nx;
  logic                done_nx;
  logic [1:0]          gnt_q, sel_i_q, sel_o_q;
  logic                busy_q, done_q;

  act_rr_arb u_arb (
    .clk (clk),
    .rst (rst),
    .req ({bus.req2, bus.req1}),
    .en  (state == ST_IDLE),
    .gnt (arb_gnt),
    .ptr (arb_ptr)
  );

  // The pointer flips away from the winner at grant and holds for the whole
  // burst, so the burst source is simply its complement.
  assign src   = ~arb_ptr;
  assign cnt_z = (cnt == '0);

  // Next state and burst counter; the counter stops at zero so len = all ones is safe.
  always_comb begin
    state_nx = state;
    cnt_nx   = cnt;
    dst_nx   = dst;
    case (state)
      ST_IDLE: if (|arb_gnt) begin
        dst_nx   = arb_gnt[1] ? bus.dst2 : bus.dst1;
        cnt_nx   = arb_gnt[1] ? bus.len2 : bus.len1;
        state_nx = (arb_gnt[1] != dst_nx) ? ST_FILL : ST_LOAD;
      end
      ST_FILL, ST_FLOW: begin
        state_nx = cnt_z ? ST_DRAIN : ST_FLOW;
        if (!cnt_z) cnt_nx = cnt - 1'b1;
      end
      ST_DRAIN: state_nx = ST_TURN;
      ST_LOAD:  state_nx = ST_DRIVE;
      ST_DRIVE: begin
        state_nx = cnt_z ? ST_TURN : ST_LOAD;
        if (!cnt_z) cnt_nx = cnt - 1'b1;
      end
      default:  state_nx = ST_IDLE;
    endcase
  end

  // Unit controls implied by the current state (bit 0 of sel_o = act1).
  always_comb begin
    sel_i_nx = SEL_NONE;
    sel_o_nx = 2'b00;
    done_nx  = 1'b0;
    case (state)
      ST_FILL:  sel_i_nx = sel_of(src);
      ST_FLOW: begin
        sel_i_nx = sel_of(src);
        sel_o_nx = dst ? 2'b10 : 2'b01;
      end
      ST_DRAIN: begin
        sel_o_nx = dst ? 2'b10 : 2'b01;
        done_nx  = 1'b1;
      end
      ST_LOAD:  sel_i_nx = sel_of(src);
      ST_DRIVE: begin
        sel_o_nx = src ? 2'b10 : 2'b01;
        done_nx  = cnt_z;
      end
      default: ;
    endcase
  end

  // FSM state register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= ST_IDLE;
      cnt   <= '0;
      dst   <= 1'b0;
    end else begin
      state <= state_nx;
      cnt   <= cnt_nx;
      dst   <= dst_nx;
    end
  end

  // Output registers; cleared asynchronously so an aborted burst leaves nothing driven.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      gnt_q   <= 2'b00;
      sel_i_q <= SEL_NONE;
      sel_o_q <= 2'b00;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      gnt_q   <= arb_gnt;
      sel_i_q <= sel_i_nx;
      sel_o_q <= sel_o_nx;
      busy_q  <= (state != ST_IDLE);
      done_q  <= done_nx;
    end
  end

  assign bus.gnt1   = gnt_q[0];
  assign bus.gnt2   = gnt_q[1];
  assign bus.sel_i  = sel_i_q;
  assign bus.sel_o1 = sel_o_q[0];
  assign bus.sel_o2 = sel_o_q[1];
  assign bus.busy   = busy_q;
  assign bus.done   = done_q;

endmodule

// File: tb/tb_act_port_sched.sv
// Bench for act_port_sched: burst-level reference model plus directed timing pins.
module tb_act_port_sched;
  import act_pkg::*;

  localparam int LW = 8;

  logic clk = 1'b0;
  logic rst = 1'b0;
  int   checks = 0;
  int   errors = 0;
  bit   chk_en = 1'b0;

  always #5 clk = ~clk;

  act_port_sched_if #(.LenWidth(LW)) bus ();
  act_port_sched #(.LenWidth(LW)) dut (.clk(clk), .rst(rst), .bus(bus));

  typedef struct packed {
    logic       g2, g1;
    logic [1:0] si;
    logic       o2, o1, busy, done;
  } out_t;

  out_t mq[$];
  out_t exp_o = '0;
  bit   m_ptr = 1'b0;

  function automatic out_t cur_out();
    out_t o;
    o = {bus.gnt2, bus.gnt1, bus.sel_i, bus.sel_o2, bus.sel_o1, bus.busy, bus.done};
    return o;
  endfunction

  task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s @%0t: got %h want %h", name, $time, act, exp);
    end
  endtask

  // Reference model: when idle and a request is seen, the whole burst's
  // per-cycle output trace is laid out in a queue from the timing rules.
  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      mq.delete();
      exp_o = '0;
      m_ptr = 1'b0;
    end else if (mq.size() != 0) begin
      exp_o = mq.pop_front();
    end else begin
      exp_o = '0;
      if (bus.req1 || bus.req2) begin
        bit   s, d;
        int   n;
        out_t e;
        s = (bus.req1 && bus.req2) ? m_ptr : bus.req2;
        m_ptr = !s;
        d = s ? bus.dst2 : bus.dst1;
        n = int'(s ? bus.len2 : bus.len1) + 1;
        exp_o.g1 = !s;
        exp_o.g2 = s;
        if (s != d) begin
          for (int k = 1; k <= n + 2; k++) begin
            e = '0;
            e.busy = 1'b1;
            if (k <= n) e.si = s ? SEL_ACT2 : SEL_ACT1;
            if (k >= 2 && k <= n + 1) begin e.o1 = !d; e.o2 = d; end
            e.done = (k == n + 1);
            mq.push_back(e);
          end
        end else begin
          for (int k = 1; k <= 2 * n + 1; k++) begin
            e = '0;
            e.busy = 1'b1;
            if (k <= 2 * n && k % 2 == 1) e.si = s ? SEL_ACT2 : SEL_ACT1;
            if (k <= 2 * n && k % 2 == 0) begin e.o1 = !s; e.o2 = s; end
            e.done = (k == 2 * n);
            mq.push_back(e);
          end
        end
      end
    end
  end

  // Every cycle: outputs against the model, plus the safety invariants.
  always @(negedge clk) begin
    if (chk_en) begin
      out_t a;
      a = cur_out();
      chk("model", 16'(a), 16'(exp_o));
      checks++;
      if ((a.o1 && a.o2) || (a.g1 && a.g2) || a.si == 2'b01 ||
          (a.o1 && a.si == SEL_ACT1) || (a.o2 && a.si == SEL_ACT2)) begin
        errors++;
        $display("FAIL invariant @%0t: outputs %b", $time, a);
      end
    end
  end

  task automatic wait_gnt(output int who, output int cyc, output bit saw_done);
    who = 0;
    saw_done = 1'b0;
    cyc = 0;
    for (int i = 1; i <= 600; i++) begin
      @(negedge clk);
      cyc = i;
      if (bus.done) saw_done = 1'b1;
      if (bus.gnt1 || bus.gnt2) begin
        who = bus.gnt2 ? 2 : 1;
        return;
      end
    end
    checks++;
    errors++;
    $display("FAIL gnt_timeout @%0t: got no grant want a grant", $time);
  endtask

  initial begin
    int   who, cyc, ocnt;
    bit   sd, got_done;
    out_t e;

    bus.req1 = 1'b0; bus.req2 = 1'b0;
    bus.dst1 = 1'b0; bus.dst2 = 1'b0;
    bus.len1 = '0;   bus.len2 = '0;
    rst = 1'b0;
    repeat (2) @(negedge clk);
    chk("reset_state", 16'(cur_out()), 16'h0);
    chk_en = 1'b1;
    rst = 1'b1;

    // Cross burst: act1 -> act2, 4 words.
    bus.req1 = 1'b1; bus.dst1 = 1'b1; bus.len1 = 8'd3;
    wait_gnt(who, cyc, sd);
    chk("cross_gnt", 16'(who), 16'd1);
    bus.req1 = 1'b0;
    for (int k = 1; k <= 7; k++) begin
      e = '0;
      e.si = (k <= 4) ? SEL_ACT1 : SEL_NONE;
      e.o2 = (k >= 2 && k <= 5);
      e.done = (k == 5);
      e.busy = (k <= 6);
      @(negedge clk);
      chk($sformatf("cross_k%0d", k), 16'(cur_out()), 16'(e));
    end

    // Same-port burst on act2, 2 words.
    bus.req2 = 1'b1; bus.dst2 = 1'b1; bus.len2 = 8'd1;
    wait_gnt(who, cyc, sd);
    chk("same_gnt", 16'(who), 16'd2);
    bus.req2 = 1'b0;
    for (int k = 1; k <= 5; k++) begin
      e = '0;
      e.si = (k == 1 || k == 3) ? SEL_ACT2 : SEL_NONE;
      e.o2 = (k == 2 || k == 4);
      e.done = (k == 4);
      e.busy = (k <= 5);
      @(negedge clk);
      chk($sformatf("same_k%0d", k), 16'(cur_out()), 16'(e));
    end

    // Single-word cross burst: FILL straight to DRAIN.
    bus.req1 = 1'b1; bus.dst1 = 1'b1; bus.len1 = 8'd0;
    wait_gnt(who, cyc, sd);
    chk("single_gnt", 16'(who), 16'd1);
    bus.req1 = 1'b0;
    for (int k = 1; k <= 3; k++) begin
      e = '0;
      e.si = (k == 1) ? SEL_ACT1 : SEL_NONE;
      e.o2 = (k == 2);
      e.done = (k == 2);
      e.busy = 1'b1;
      @(negedge clk);
      chk($sformatf("single_k%0d", k), 16'(cur_out()), 16'(e));
    end

    // Contention from reset: act1 same-port 1 word, act2 cross 2 words.
    @(negedge clk); #1 rst = 1'b0;
    bus.req1 = 1'b1; bus.dst1 = 1'b0; bus.len1 = 8'd0;
    bus.req2 = 1'b1; bus.dst2 = 1'b0; bus.len2 = 8'd1;
    @(negedge clk); #1 rst = 1'b1;
    wait_gnt(who, cyc, sd);
    chk("cont_g1", 16'(who), 16'd1);
    wait_gnt(who, cyc, sd);
    chk("cont_g2", 16'(who), 16'd2);
    chk("cont_gap1", 16'(cyc), 16'd4);
    wait_gnt(who, cyc, sd);
    chk("cont_g3", 16'(who), 16'd1);
    chk("cont_gap2", 16'(cyc), 16'd5);
    bus.req1 = 1'b0; bus.req2 = 1'b0;

    // Reset during FLOW of an 8-word cross burst.
    bus.req1 = 1'b1; bus.dst1 = 1'b1; bus.len1 = 8'd7;
    wait_gnt(who, cyc, sd);
    chk("abort_gnt", 16'(who), 16'd1);
    bus.req1 = 1'b0;
    repeat (3) @(negedge clk);
    e = '0; e.si = SEL_ACT1; e.o2 = 1'b1; e.busy = 1'b1;
    chk("abort_flow", 16'(cur_out()), 16'(e));
    @(posedge clk); #2 rst = 1'b0;
    #1 chk("abort_async", 16'(cur_out()), 16'h0);
    bus.req1 = 1'b1; bus.req2 = 1'b1;
    @(negedge clk); #1 rst = 1'b1;
    wait_gnt(who, cyc, sd);
    chk("abort_regrant", 16'(who), 16'd1);
    chk("abort_no_done", 16'(sd), 16'd0);
    bus.req1 = 1'b0; bus.req2 = 1'b0;

    // Maximum length cross burst: 256 words.
    bus.req1 = 1'b1; bus.dst1 = 1'b1; bus.len1 = 8'd255;
    wait_gnt(who, cyc, sd);
    bus.req1 = 1'b0;
    ocnt = 0;
    got_done = 1'b0;
    for (int i = 0; i < 300 && !got_done; i++) begin
      @(negedge clk);
      if (bus.sel_o2) ocnt++;
      if (bus.done) got_done = 1'b1;
    end
    chk("max_done", 16'(got_done), 16'd1);
    chk("max_words", 16'(ocnt), 16'd256);

    // Random traffic, occasional asynchronous reset.
    for (int i = 0; i < 4000; i++) begin
      @(negedge clk);
      #1;
      rst = ($urandom % 400) != 0;
      bus.req1 = ($urandom % 3) == 0;
      bus.req2 = ($urandom % 3) == 0;
      bus.dst1 = 1'($urandom % 2);
      bus.dst2 = 1'($urandom % 2);
      bus.len1 = (($urandom % 16) == 0) ? 8'($urandom) : 8'($urandom % 4);
      bus.len2 = (($urandom % 16) == 0) ? 8'($urandom) : 8'($urandom % 4);
    end
    @(negedge clk);
    #1 rst = 1'b1;
    bus.req1 = 1'b0; bus.req2 = 1'b0;
    repeat (10) @(negedge clk);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/act_port_sched.md
# act_port_sched

Sequencer and arbiter for the shared activation unit in the Spiral NN engine. Two neighbour ports (act1, act2) share one retimed activation stage whose data moves over bidirectional nets. The block grants bursts to one requester at a time and drives the unit's input select (sel_i) and output enables (sel_o1/sel_o2). It guarantees that no net is ever driven and sampled in the same cycle, and that a turnaround cycle follows every burst.

## Interface
- LenWidth, 8, width of burst length fields; burst = len+1 words (1..2^LenWidth)
- clk  in  1  clock, rising edge
- rst  in  1  reset, asynchronous, active-low
- req1 / req2  in  1  burst request whose source is act1 / act2; held until granted
- dst1 / dst2  in  1  destination of that request: 0 = act1, 1 = act2; sampled at grant
- len1 / len2  in  LenWidth  burst length minus one; sampled at grant
- gnt1 / gnt2  out  1  one-cycle grant pulse; reset 0
- sel_i  out  2  unit input select: 00 none, 10 act1, 11 act2, 01 never driven; reset 00
- sel_o1 / sel_o2  out  1  unit drives act1 / act2; reset 0
- busy  out  1  high from the cycle after grant through TURN; reset 0
- done  out  1  one-cycle pulse coincident with the last output word; reset 0

## Operation
- All outputs are registered.
- States: IDLE, FILL, FLOW, DRAIN, LOAD, DRIVE, TURN.
- IDLE: requests are sampled only in this state.
  - If any request is present: pulse the grant and latch src, dst and len into a down-counter.
  - Next state is FILL if src != dst (cross mode), else LOAD (same-port mode).
- Arbitration is 2-way round-robin.
  - After reset the pointer favours req1.
  - After each grant the pointer favours the other port.
  - A single requester is always granted.
- Cross mode (pipelined, 1 word/cycle):
  - FILL: sel_i = src, outputs off. Decrement the counter. Go to FLOW if more words remain, else DRAIN.
  - FLOW: sel_i = src and sel_o[dst] = 1. Decrement the counter. Go to DRAIN when the last word has been loaded.
  - DRAIN: sel_i = 00, sel_o[dst] = 1, done = 1. Go to TURN.
- Same-port mode (half rate; a net is never read and driven in the same cycle):
  - LOAD: sel_i = src, outputs off. Go to DRIVE.
  - DRIVE: sel_o[src] = 1, sel_i = 00. Decrement the counter. Go to LOAD if words remain; otherwise raise done and go to TURN.
- TURN: all selects off. Go to IDLE. No grant is issued in TURN.
- Invariants, checked at all times:
  - sel_o1 and sel_o2 are never both high.
  - sel_o[x] is never high while sel_i selects port x.
  - gnt1 and gnt2 are never both high.
- A request dropped before its grant has no effect. Requests during a burst are ignored until IDLE.
- Reset asserted mid-burst:
  - All outputs go to their reset values immediately (asynchronous).
  - FSM returns to IDLE and the arbiter pointer returns to req1.
  - No done pulse is issued for the aborted burst.

## Timing
- Grant at cycle T (IDLE).
- Cross mode, N words:
  - sel_i active T+1..T+N.
  - sel_o active T+2..T+N+1.
  - done at T+N+1, TURN at T+N+2, next grant possible at T+N+3.
- Same-port mode, N words:
  - LOAD at T+1, T+3, …, T+2N−1.
  - DRIVE at T+2, …, T+2N.
  - done at T+2N, TURN at T+2N+1, next grant at T+2N+2.
- N=1 cross: FILL, then DRAIN directly (no FLOW).
- Maximum length (len = all ones) must not overflow the counter. The counter width is LenWidth and it terminates at zero.

## Structure
- Package act_pkg holds:
  - the state enum;
  - sel_i encodings SEL_NONE = 00, SEL_ACT1 = 10, SEL_ACT2 = 11;
  - the LenWidth default.
- Sub-module act_rr_arb: 2-requester round-robin arbiter.
  - Inputs: req, an enable (high only in IDLE), clk, rst.
  - Outputs: a one-hot grant and the pointer update.

## Test plan
- Cross burst: req1, dst1=1, len1=3, alone.
  - gnt1 at T.
  - sel_i = 10 at T+1..T+4.
  - sel_o2 at T+2..T+5.
  - done at T+5, busy low at T+7.
- Same-port burst: req2, dst2=1, len2=1.
  - gnt2 at T.
  - sel_i = 11 at T+1 and T+3.
  - sel_o2 at T+2 and T+4 only.
  - done at T+4.
- Contention: req1 and req2 held together from reset.
  - Grants alternate gnt1, gnt2, gnt1.
  - Each grant follows the previous TURN.
- Single-word cross burst: len1 = 0.
  - FILL then DRAIN: sel_i at T+1, sel_o2 at T+2, done at T+2.
- Reset mid-burst: deassert rst during FLOW.
  - All outputs 0 in the same cycle.
  - Next request is granted to req1 without a done pulse.
- Maximum length: len = 255, cross mode.
  - Exactly 256 sel_o cycles, then done.
- Continuous assertion check over random traffic: all invariants hold throughout.
